// File: rtl/controller.sv
// ---------------------------------------------------------------------------
// controller -- single-cycle RV32I control unit with program counter.
//
// Holds the byte program counter and decodes the fetched instruction into
// register-file, ALU and data-memory control signals in the same cycle.
// The next PC (sequential, jump, taken branch or JALR target) is loaded on
// every rising clock edge while reset is high.
//
// Optional feature macro: CONTROLLER_UNSIGNED_BRANCH_EN
//   defined   -> BLTU/BGEU decode as branches (FS=SUBU, taken on N / !N)
//   undefined -> BLTU/BGEU decode as NOP (no writes, PC+4)
//
// Parameter:
//   size          datapath width; register count also equals size
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (PC forced to 0)
//   instruction   RV32I word fetched from PC_Addr
//   IMM_rs        rs1 value, base address for JALR
//   Z, N          datapath zero / less-than flags for branch compares
//   PC_Addr       instruction word address (byte PC >> 2)
//   PC_Save       byte PC + 4 (link value)
//   IMM_out       decoded immediate or computed operand, 0 when unused
//   Mem_type_sel  load/store type (funct3)
//   A_select      rs1 index
//   B_select      rs2 index
//   D_addr        rd index
//   we            register-file write enable
//   MR            data-memory write enable (stores)
//   MD            selects memory data onto the D bus (loads)
//   MB            selects IMM_out as ALU operand B
//   FS            ALU function select
// ---------------------------------------------------------------------------
module controller #(
    parameter int size = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instruction,
    input  logic [size-1:0]         IMM_rs,
    input  logic                    Z,
    input  logic                    N,
    output logic [size-1:0]         PC_Addr,
    output logic [size-1:0]         PC_Save,
    output logic [size-1:0]         IMM_out,
    output logic [2:0]              Mem_type_sel,
    output logic [$clog2(size)-1:0] A_select,
    output logic [$clog2(size)-1:0] B_select,
    output logic [$clog2(size)-1:0] D_addr,
    output logic                    we,
    output logic                    MR,
    output logic                    MD,
    output logic                    MB,
    output logic [3:0]              FS
);

    localparam int AW = $clog2(size);

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU function select encoding
    localparam logic [3:0] FS_ADD    = 4'b0000;
    localparam logic [3:0] FS_SUB    = 4'b0001;
    localparam logic [3:0] FS_SLL    = 4'b0010;
    localparam logic [3:0] FS_SLT    = 4'b0011;
    localparam logic [3:0] FS_SLTU   = 4'b0100;
    localparam logic [3:0] FS_XOR    = 4'b0101;
    localparam logic [3:0] FS_SRL    = 4'b0110;
    localparam logic [3:0] FS_SRA    = 4'b0111;
    localparam logic [3:0] FS_OR     = 4'b1000;
    localparam logic [3:0] FS_AND    = 4'b1001;
    localparam logic [3:0] FS_PASS_B = 4'b1010;
    localparam logic [3:0] FS_SUBU   = 4'b1011;

    // Byte program counter
    logic [size-1:0] pc_q;
    logic [size-1:0] pc_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    // Sign-extended immediates
    logic [size-1:0] i_imm;
    logic [size-1:0] s_imm;
    logic [size-1:0] b_imm;
    logic [size-1:0] u_imm;
    logic [size-1:0] j_imm;

    logic [size-1:0] pc_plus4;
    logic [size-1:0] jalr_sum;

    // Decoded write enables before the reset override
    logic dec_we;
    logic dec_mr;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    assign i_imm = size'($signed(instruction[31:20]));
    assign s_imm = size'($signed({instruction[31:25], instruction[11:7]}));
    assign b_imm = size'($signed({instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8], 1'b0}));
    assign u_imm = size'($signed({instruction[31:12], 12'b0}));
    assign j_imm = size'($signed({instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21], 1'b0}));

    assign pc_plus4 = pc_q + size'(4);
    assign jalr_sum = IMM_rs + i_imm;

    assign PC_Addr      = pc_q >> 2;
    assign PC_Save      = pc_plus4;
    assign Mem_type_sel = funct3;
    assign A_select     = AW'(instruction[19:15]);
    assign B_select     = AW'(instruction[24:20]);
    assign D_addr       = AW'(instruction[11:7]);

    // Reset is asynchronous, so the write strobes must drop with it rather
    // than wait for a clock edge.
    assign we = dec_we & reset;
    assign MR = dec_mr & reset;

    // ALU function from funct3. funct7[5] selects SUB only for register-
    // register ops (ADDI has no subtract form); for shifts-right it selects
    // the arithmetic variant in both OP and OP-IMM.
    function automatic logic [3:0] alu_fs(input logic [2:0] f3,
                                          input logic       f7b5,
                                          input logic       is_reg);
        logic [3:0] fs;
        case (f3)
            3'b000:  fs = (is_reg && f7b5) ? FS_SUB : FS_ADD;
            3'b001:  fs = FS_SLL;
            3'b010:  fs = FS_SLT;
            3'b011:  fs = FS_SLTU;
            3'b100:  fs = FS_XOR;
            3'b101:  fs = f7b5 ? FS_SRA : FS_SRL;
            3'b110:  fs = FS_OR;
            default: fs = FS_AND;
        endcase
        return fs;
    endfunction

    always_comb begin
        dec_we  = 1'b0;
        dec_mr  = 1'b0;
        MD      = 1'b0;
        MB      = 1'b0;
        FS      = FS_ADD;
        IMM_out = '0;
        pc_d    = pc_plus4;

        case (opcode)
            OPC_OP: begin
                dec_we = 1'b1;
                FS     = alu_fs(funct3, funct7_b5, 1'b1);
            end
            OPC_OP_IMM: begin
                dec_we  = 1'b1;
                MB      = 1'b1;
                FS      = alu_fs(funct3, funct7_b5, 1'b0);
                IMM_out = i_imm;
            end
            OPC_LOAD: begin
                dec_we  = 1'b1;
                MD      = 1'b1;
                MB      = 1'b1;
                IMM_out = i_imm;
            end
            OPC_STORE: begin
                dec_mr  = 1'b1;
                MB      = 1'b1;
                IMM_out = s_imm;
            end
            OPC_LUI: begin
                dec_we  = 1'b1;
                MB      = 1'b1;
                FS      = FS_PASS_B;
                IMM_out = u_imm;
            end
            OPC_AUIPC: begin
                dec_we  = 1'b1;
                MB      = 1'b1;
                FS      = FS_PASS_B;
                IMM_out = pc_q + u_imm;
            end
            OPC_JAL: begin
                dec_we  = 1'b1;
                MB      = 1'b1;
                FS      = FS_PASS_B;
                IMM_out = pc_plus4;
                pc_d    = pc_q + j_imm;
            end
            OPC_JALR: begin
                dec_we  = 1'b1;
                MB      = 1'b1;
                FS      = FS_PASS_B;
                IMM_out = pc_plus4;
                pc_d    = {jalr_sum[size-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                // Reserved funct3 values (010/011) and, without the unsigned
                // option, BLTU/BGEU fall through as NOP with FS left at ADD.
                case (funct3)
                    3'b000: begin
                        FS = FS_SUB;
                        if (Z) pc_d = pc_q + b_imm;
                    end
                    3'b001: begin
                        FS = FS_SUB;
                        if (!Z) pc_d = pc_q + b_imm;
                    end
                    3'b100: begin
                        FS = FS_SUB;
                        if (N) pc_d = pc_q + b_imm;
                    end
                    3'b101: begin
                        FS = FS_SUB;
                        if (!N) pc_d = pc_q + b_imm;
                    end
`ifdef CONTROLLER_UNSIGNED_BRANCH_EN
                    3'b110: begin
                        FS = FS_SUBU;
                        if (N) pc_d = pc_q + b_imm;
                    end
                    3'b111: begin
                        FS = FS_SUBU;
                        if (!N) pc_d = pc_q + b_imm;
                    end
`endif
                    default: begin
                        FS = FS_ADD;
                    end
                endcase
            end
            default: begin
                // Unknown opcode: NOP, all defaults hold.
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_controller.sv
// ---------------------------------------------------------------------------
// tb_controller -- directed testbench for the controller block.
// Each task drives one scenario and checks outputs against hand-computed
// values; the run ends with a single summary line.
// ---------------------------------------------------------------------------
module tb_controller;

    localparam logic [31:0] I_NOP   = 32'h0000_0013; // ADDI x0,x0,0
    localparam logic [31:0] I_ADDI5 = 32'h0050_0093; // ADDI x1,x0,5
    localparam logic [31:0] I_ADDIM = 32'hFFF0_0093; // ADDI x1,x0,-1
    localparam logic [31:0] I_JAL16 = 32'h0100_00EF; // JAL x1,+16
    localparam logic [31:0] I_JALR  = 32'h0032_8067; // JALR x0,3(x5)
    localparam logic [31:0] I_BEQM8 = 32'hFE00_0CE3; // BEQ x0,x0,-8
    localparam logic [31:0] I_BLT8  = 32'h0020_C463; // BLT x1,x2,+8
    localparam logic [31:0] I_BLTU8 = 32'h0020_E463; // BLTU x1,x2,+8
    localparam logic [31:0] I_SW    = 32'h0021_A423; // SW x2,8(x3)
    localparam logic [31:0] I_LBU   = 32'h0000_C283; // LBU x5,0(x1)
    localparam logic [31:0] I_LUI   = 32'h1234_51B7; // LUI x3,0x12345
    localparam logic [31:0] I_AUIPC = 32'h1234_5197; // AUIPC x3,0x12345
    localparam logic [31:0] I_SUB   = 32'h4020_81B3; // SUB x3,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h4030_D093; // SRAI x1,x1,3
    localparam logic [31:0] I_BAD   = 32'h0000_007F; // unknown opcode

    // clock / reset
    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [31:0] imm_rs;
    logic        z_flag;
    logic        n_flag;

    logic [31:0] pc_addr;
    logic [31:0] pc_save;
    logic [31:0] imm_out;
    logic [2:0]  mem_type_sel;
    logic [4:0]  a_select;
    logic [4:0]  b_select;
    logic [4:0]  d_addr;
    logic        we;
    logic        mr;
    logic        md;
    logic        mb;
    logic [3:0]  fs;

    int total;
    int bad;

    controller #(.size(32)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .instruction  (instruction),
        .IMM_rs       (imm_rs),
        .Z            (z_flag),
        .N            (n_flag),
        .PC_Addr      (pc_addr),
        .PC_Save      (pc_save),
        .IMM_out      (imm_out),
        .Mem_type_sel (mem_type_sel),
        .A_select     (a_select),
        .B_select     (b_select),
        .D_addr       (d_addr),
        .we           (we),
        .MR           (mr),
        .MD           (md),
        .MB           (mb),
        .FS           (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        instruction = I_NOP;
        imm_rs      = '0;
        z_flag      = 1'b0;
        n_flag      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic step_nop(input int n);
        instruction = I_NOP;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instruction = I_ADDI5;
        imm_rs      = '0;
        z_flag      = 1'b0;
        n_flag      = 1'b0;
        #2;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", we); end
        total++; if (pc_addr !== 32'd0) begin bad++; $display("FAIL rst_pc_addr got=%0d exp=0", pc_addr); end
        total++; if (pc_save !== 32'd4) begin bad++; $display("FAIL rst_pc_save got=%0d exp=4", pc_save); end
        tick();
        total++; if (pc_addr !== 32'd0) begin bad++; $display("FAIL rst_hold_pc got=%0d exp=0", pc_addr); end
        rst_n = 1'b1;
        #1;
        total++; if (a_select !== 5'd0) begin bad++; $display("FAIL addi_a_sel got=%0d exp=0", a_select); end
        total++; if (d_addr !== 5'd1) begin bad++; $display("FAIL addi_d_addr got=%0d exp=1", d_addr); end
        total++; if (imm_out !== 32'd5) begin bad++; $display("FAIL addi_imm got=%0d exp=5", imm_out); end
        total++; if (mb !== 1'b1) begin bad++; $display("FAIL addi_mb got=%0b exp=1", mb); end
        total++; if (fs !== 4'b0000) begin bad++; $display("FAIL addi_fs got=%b exp=0000", fs); end
        total++; if (we !== 1'b1) begin bad++; $display("FAIL addi_we got=%0b exp=1", we); end
        tick();
        total++; if (pc_addr !== 32'd1) begin bad++; $display("FAIL addi_next_pc got=%0d exp=1", pc_addr); end
    endtask

    task automatic test_jal();
        do_reset();
        step_nop(2);                       // PC = 8
        instruction = I_JAL16;
        #1;
        total++; if (imm_out !== 32'd12) begin bad++; $display("FAIL jal_imm got=%0d exp=12", imm_out); end
        total++; if (pc_save !== 32'd12) begin bad++; $display("FAIL jal_pc_save got=%0d exp=12", pc_save); end
        total++; if (we !== 1'b1) begin bad++; $display("FAIL jal_we got=%0b exp=1", we); end
        total++; if (fs !== 4'b1010) begin bad++; $display("FAIL jal_fs got=%b exp=1010", fs); end
        tick();
        total++; if (pc_addr !== 32'd6) begin bad++; $display("FAIL jal_target got=%0d exp=6", pc_addr); end
    endtask

    task automatic test_jalr();
        do_reset();
        instruction = I_JALR;
        imm_rs      = 32'd100;
        #1;
        total++; if (we !== 1'b1) begin bad++; $display("FAIL jalr_we got=%0b exp=1", we); end
        total++; if (d_addr !== 5'd0) begin bad++; $display("FAIL jalr_d_addr got=%0d exp=0", d_addr); end
        total++; if (imm_out !== 32'd4) begin bad++; $display("FAIL jalr_link got=%0d exp=4", imm_out); end
        tick();
        // 100 + 3 = 103, bit 0 cleared -> 102
        total++; if (pc_save !== 32'd106) begin bad++; $display("FAIL jalr_target got=%0d exp=106", pc_save); end
        total++; if (pc_addr !== 32'd25) begin bad++; $display("FAIL jalr_pc_addr got=%0d exp=25", pc_addr); end
        // wrap: 0xFFFFFFFC + 3 = 0xFFFFFFFF -> 0xFFFFFFFE, link wraps to 2
        do_reset();
        instruction = I_JALR;
        imm_rs      = 32'hFFFF_FFFC;
        tick();
        total++; if (pc_save !== 32'd2) begin bad++; $display("FAIL jalr_wrap got=%0h exp=2", pc_save); end
        total++; if (pc_addr !== 32'h3FFF_FFFF) begin bad++; $display("FAIL jalr_wrap_addr got=%0h exp=3fffffff", pc_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        step_nop(4);                       // PC = 16
        instruction = I_BEQM8;
        z_flag      = 1'b1;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL beq_we got=%0b exp=0", we); end
        total++; if (fs !== 4'b0001) begin bad++; $display("FAIL beq_fs got=%b exp=0001", fs); end
        total++; if (mb !== 1'b0) begin bad++; $display("FAIL beq_mb got=%0b exp=0", mb); end
        total++; if (imm_out !== 32'd0) begin bad++; $display("FAIL beq_imm got=%0d exp=0", imm_out); end
        tick();
        total++; if (pc_save !== 32'd12) begin bad++; $display("FAIL beq_taken got=%0d exp=12", pc_save); end
        step_nop(2);                       // PC = 16
        instruction = I_BEQM8;
        z_flag      = 1'b0;
        tick();
        total++; if (pc_save !== 32'd24) begin bad++; $display("FAIL beq_not_taken got=%0d exp=24", pc_save); end
        // BLT at PC 20 with N=1 -> 28
        instruction = I_BLT8;
        n_flag      = 1'b1;
        #1;
        total++; if (fs !== 4'b0001) begin bad++; $display("FAIL blt_fs got=%b exp=0001", fs); end
        tick();
        total++; if (pc_save !== 32'd32) begin bad++; $display("FAIL blt_taken got=%0d exp=32", pc_save); end
        n_flag = 1'b0;
    endtask

    task automatic test_mem();
        instruction = I_SW;
        #1;
        total++; if (mr !== 1'b1) begin bad++; $display("FAIL sw_mr got=%0b exp=1", mr); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL sw_we got=%0b exp=0", we); end
        total++; if (mb !== 1'b1) begin bad++; $display("FAIL sw_mb got=%0b exp=1", mb); end
        total++; if (imm_out !== 32'd8) begin bad++; $display("FAIL sw_imm got=%0d exp=8", imm_out); end
        total++; if (mem_type_sel !== 3'b010) begin bad++; $display("FAIL sw_type got=%b exp=010", mem_type_sel); end
        total++; if (md !== 1'b0) begin bad++; $display("FAIL sw_md got=%0b exp=0", md); end
        instruction = I_LBU;
        #1;
        total++; if (md !== 1'b1) begin bad++; $display("FAIL lbu_md got=%0b exp=1", md); end
        total++; if (mem_type_sel !== 3'b100) begin bad++; $display("FAIL lbu_type got=%b exp=100", mem_type_sel); end
        total++; if (we !== 1'b1) begin bad++; $display("FAIL lbu_we got=%0b exp=1", we); end
        total++; if (mr !== 1'b0) begin bad++; $display("FAIL lbu_mr got=%0b exp=0", mr); end
    endtask

    task automatic test_ops();
        do_reset();
        step_nop(1);                       // PC = 4
        instruction = I_LUI;
        #1;
        total++; if (imm_out !== 32'h1234_5000) begin bad++; $display("FAIL lui_imm got=%0h exp=12345000", imm_out); end
        total++; if (fs !== 4'b1010) begin bad++; $display("FAIL lui_fs got=%b exp=1010", fs); end
        instruction = I_AUIPC;
        #1;
        total++; if (imm_out !== 32'h1234_5004) begin bad++; $display("FAIL auipc_imm got=%0h exp=12345004", imm_out); end
        instruction = I_SUB;
        #1;
        total++; if (fs !== 4'b0001) begin bad++; $display("FAIL sub_fs got=%b exp=0001", fs); end
        total++; if (mb !== 1'b0) begin bad++; $display("FAIL sub_mb got=%0b exp=0", mb); end
        total++; if (b_select !== 5'd2) begin bad++; $display("FAIL sub_b_sel got=%0d exp=2", b_select); end
        instruction = I_SRAI;
        #1;
        total++; if (fs !== 4'b0111) begin bad++; $display("FAIL srai_fs got=%b exp=0111", fs); end
        total++; if (imm_out !== 32'h0000_0403) begin bad++; $display("FAIL srai_imm got=%0h exp=403", imm_out); end
        instruction = I_ADDIM;
        #1;
        total++; if (imm_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_neg_imm got=%0h exp=ffffffff", imm_out); end
    endtask

    task automatic test_nop_unsigned();
        logic [31:0] exp_save;
        do_reset();
        instruction = I_BAD;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL bad_op_we got=%0b exp=0", we); end
        total++; if (mr !== 1'b0) begin bad++; $display("FAIL bad_op_mr got=%0b exp=0", mr); end
        tick();
        total++; if (pc_addr !== 32'd1) begin bad++; $display("FAIL bad_op_pc got=%0d exp=1", pc_addr); end
        // BLTU at PC 4 with N=1
        instruction = I_BLTU8;
        n_flag      = 1'b1;
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL bltu_we got=%0b exp=0", we); end
`ifdef CONTROLLER_UNSIGNED_BRANCH_EN
        total++; if (fs !== 4'b1011) begin bad++; $display("FAIL bltu_fs got=%b exp=1011", fs); end
        exp_save = 32'd16;                 // taken: 4 + 8 = 12
`else
        total++; if (fs !== 4'b0000) begin bad++; $display("FAIL bltu_fs got=%b exp=0000", fs); end
        exp_save = 32'd12;                 // NOP: 4 + 4 = 8
`endif
        tick();
        total++; if (pc_save !== exp_save) begin bad++; $display("FAIL bltu_next got=%0d exp=%0d", pc_save, exp_save); end
        n_flag = 1'b0;
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        step_nop(2);                       // PC = 8
        instruction = I_JAL16;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (pc_addr !== 32'd0) begin bad++; $display("FAIL midjump_pc got=%0d exp=0", pc_addr); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL midjump_we got=%0b exp=0", we); end
        tick();
        total++; if (pc_addr !== 32'd0) begin bad++; $display("FAIL midjump_hold got=%0d exp=0", pc_addr); end
        rst_n       = 1'b1;
        instruction = I_NOP;
        tick();
        total++; if (pc_addr !== 32'd1) begin bad++; $display("FAIL midjump_resume got=%0d exp=1", pc_addr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_jal();
        test_jalr();
        test_branch();
        test_mem();
        test_ops();
        test_nop_unsigned();
        test_reset_mid_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
